// File: rtl/pwm_capture.sv
// PWM duty-cycle meter: counts period and high time between synchronised rising edges,
// then divides serially to a 0..100 percent result. Optional port period_o via PWM_CAPTURE_PERIOD_OUT_EN.
module pwm_capture #(
    parameter int unsigned clk_freq = 100_000_000,
    parameter int unsigned pwm_freq = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pwm_i,
    output logic [6:0]  duty_cycle_o,
    output logic        valid_o,
`ifdef PWM_CAPTURE_PERIOD_OUT_EN
    output logic [31:0] period_o,
`endif
    output logic        timeout_o
);

    localparam int unsigned c_timerlim = clk_freq / pwm_freq;
    localparam int unsigned c_timeout  = 2 * c_timerlim;
    localparam logic [31:0] tmo_last   = 32'(c_timeout - 1);

    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

    state_t      state;
    logic        sync1, sync2, sync3;
    logic [31:0] period_cnt, high_cnt, period_cap, tmo_cnt;
    logic [39:0] rem, div_sub;
    logic [6:0]  quo;
    logic [2:0]  div_step;
    logic        publish;
    logic        edge_det, tmo_hit;

    always_comb begin
        edge_det = sync2 & ~sync3;
        tmo_hit  = (tmo_cnt == tmo_last) && !edge_det;
        div_sub  = {8'd0, period_cap} << div_step;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            sync3        <= 1'b0;
            period_cnt   <= '0;
            high_cnt     <= '0;
            period_cap   <= '0;
            tmo_cnt      <= '0;
            rem          <= '0;
            quo          <= '0;
            div_step     <= '0;
            publish      <= 1'b0;
            duty_cycle_o <= '0;
            valid_o      <= 1'b0;
            timeout_o    <= 1'b0;
`ifdef PWM_CAPTURE_PERIOD_OUT_EN
            period_o     <= '0;
`endif
        end else begin
            sync1     <= pwm_i;
            sync2     <= sync1;
            sync3     <= sync2;
            valid_o   <= 1'b0;
            timeout_o <= 1'b0;

            if (edge_det || tmo_hit)
                tmo_cnt <= '0;
            else if (tmo_cnt != '1)
                tmo_cnt <= tmo_cnt + 32'd1;

            // Counters run through DIVIDE as well, so a short period is still measured from its edge.
            if (edge_det) begin
                period_cnt <= 32'd1;
                high_cnt   <= 32'd1;
            end else if (state != IDLE) begin
                if (period_cnt != '1)
                    period_cnt <= period_cnt + 32'd1;
                if (sync2 && high_cnt != '1)
                    high_cnt <= high_cnt + 32'd1;
            end

            if (tmo_hit) begin
                state        <= IDLE;
                publish      <= 1'b0;
                duty_cycle_o <= sync2 ? 7'd100 : 7'd0;
                valid_o      <= 1'b1;
                timeout_o    <= 1'b1;
`ifdef PWM_CAPTURE_PERIOD_OUT_EN
                period_o     <= '0;
`endif
            end else begin
                if (publish) begin
                    publish      <= 1'b0;
                    duty_cycle_o <= (quo > 7'd100) ? 7'd100 : quo;
                    valid_o      <= 1'b1;
`ifdef PWM_CAPTURE_PERIOD_OUT_EN
                    period_o     <= period_cap;
`endif
                end

                case (state)
                    IDLE: begin
                        if (edge_det)
                            state <= MEASURE;
                    end
                    MEASURE: begin
                        if (edge_det) begin
                            period_cap <= period_cnt;
                            rem        <= {8'd0, high_cnt} * 40'd100;
                            quo        <= '0;
                            div_step   <= 3'd6;
                            state      <= DIVIDE;
                        end
                    end
                    DIVIDE: begin
                        // Restoring division, quotient shifted in MSB first.
                        if (rem >= div_sub) begin
                            rem <= rem - div_sub;
                            quo <= {quo[5:0], 1'b1};
                        end else begin
                            quo <= {quo[5:0], 1'b0};
                        end
                        if (div_step == 3'd0) begin
                            state   <= MEASURE;
                            publish <= 1'b1;
                        end else begin
                            div_step <= div_step - 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with clk_freq=1000, pwm_freq=10 (timeout after 200 clocks).
// A result for a rise driven at cycle c is expected at cycle c+11 (3 sync/detect + 8).
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pwm_i = 1'b0;
    logic [6:0] duty;
    logic       valid;
    logic       tmo;
`ifdef PWM_CAPTURE_PERIOD_OUT_EN
    logic [31:0] period;
`endif

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int stray = 0;
    int rel = 0;
    int e_rise = 0;
    int ev_cyc[$];
    int ev_duty[$];
    int ev_tmo[$];
    int rq[$];

    pwm_capture #(.clk_freq(1000), .pwm_freq(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_i        (pwm_i),
        .duty_cycle_o (duty),
        .valid_o      (valid),
`ifdef PWM_CAPTURE_PERIOD_OUT_EN
        .period_o     (period),
`endif
        .timeout_o    (tmo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            ev_cyc.push_back(cyc);
            ev_duty.push_back(int'(duty));
            ev_tmo.push_back(int'(tmo));
        end
        if (tmo === 1'b1 && valid !== 1'b1)
            stray++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input int i, input int ecyc, input int eduty, input int etmo);
        chk({tag, "_cyc"},  (i < ev_cyc.size()) ? ev_cyc[i]  : -1, ecyc);
        chk({tag, "_duty"}, (i < ev_cyc.size()) ? ev_duty[i] : -1, eduty);
        chk({tag, "_tmo"},  (i < ev_cyc.size()) ? ev_tmo[i]  : -1, etmo);
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            pwm_i = v;
        end
    endtask

    task automatic period_wave(input int h, input int l);
        @(negedge clk);
        rq.push_back(cyc);
        pwm_i = 1'b1;
        drive(1'b1, h - 1);
        drive(1'b0, l);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        pwm_i = 1'b0;
        #1;
        chk("rst_duty", duty, 0);
        chk("rst_valid", valid, 0);
        chk("rst_tmo", tmo, 0);
        drive(1'b0, 3);
        @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        ev_cyc.delete();
        ev_duty.delete();
        ev_tmo.delete();
        rq.delete();
    endtask

    initial begin
        // 30/70 stream: first result on second rise, one per period
        do_reset();
        drive(1'b0, 5);
        repeat (4) period_wave(30, 70);
        chk("s1_count", ev_cyc.size(), 3);
        for (int i = 0; i < 3; i++)
            chk_ev("s1", i, rq[i + 1] + 11, 30, 0);

        // truncation and extremes
        do_reset();
        drive(1'b0, 5);
        period_wave(33, 67);
        period_wave(33, 67);
        period_wave(1, 99);
        period_wave(99, 1);
        period_wave(99, 1);
        chk("s2_count", ev_cyc.size(), 4);
        chk_ev("s2_33a", 0, rq[1] + 11, 33, 0);
        chk_ev("s2_33b", 1, rq[2] + 11, 33, 0);
        chk_ev("s2_1",   2, rq[3] + 11, 1, 0);
        chk_ev("s2_99",  3, rq[4] + 11, 99, 0);

        // held low from reset: repeating timeouts
        do_reset();
        drive(1'b0, 405);
        chk("s3_count", ev_cyc.size(), 2);
        chk_ev("s3_t200", 0, rel + 200, 0, 1);
        chk_ev("s3_t400", 1, rel + 400, 0, 1);

        // one edge then held high
        do_reset();
        drive(1'b0, 5);
        @(negedge clk);
        e_rise = cyc;
        pwm_i = 1'b1;
        drive(1'b1, 210);
        chk("s4_count", ev_cyc.size(), 1);
        chk_ev("s4_high", 0, e_rise + 203, 100, 1);

        // reset three clocks into DIVIDE
        do_reset();
        drive(1'b0, 5);
        period_wave(30, 70);
        period_wave(30, 70);
        @(negedge clk);
        rq.push_back(cyc);
        pwm_i = 1'b1;
        drive(1'b1, 5);
        chk("s5_hold", duty, 30);
        @(negedge clk);
        rst = 1'b1;
        pwm_i = 1'b0;
        #1;
        chk("s5_rst_duty", duty, 0);
        chk("s5_rst_valid", valid, 0);
        chk("s5_rst_tmo", tmo, 0);
        drive(1'b0, 2);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 3);
        repeat (3) period_wave(30, 70);
        chk("s5_count", ev_cyc.size(), 3);
        chk_ev("s5_pre",  0, rq[1] + 11, 30, 0);
        chk_ev("s5_post", 1, rq[4] + 11, 30, 0);
        chk_ev("s5_next", 2, rq[5] + 11, 30, 0);

        // 5-clock glitch period in a 30/70 stream
        do_reset();
        drive(1'b0, 5);
        period_wave(30, 70);
        period_wave(30, 70);
        period_wave(2, 3);
        period_wave(30, 70);
        period_wave(30, 70);
        chk("s6_count", ev_cyc.size(), 3);
        chk_ev("s6_a",     0, rq[1] + 11, 30, 0);
        chk_ev("s6_inflt", 1, rq[2] + 11, 30, 0);
        chk_ev("s6_after", 2, rq[4] + 11, 30, 0);

        chk("stray_timeout", stray, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter clk_freq, default 100_000_000: clock frequency in Hz.
REQ-002 SHALL have parameter pwm_freq, default 1000: nominal PWM frequency in Hz.
REQ-003 SHALL derive c_timerlim = clk_freq / pwm_freq (clocks per nominal period) and c_timeout = 2*c_timerlim.
REQ-004 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-006 SHALL have port pwm_i  input  1: asynchronous PWM waveform to measure.
REQ-007 SHALL have port duty_cycle_o  output  7: measured duty in percent, 0..100, registered.
REQ-008 SHALL have port valid_o  output  1: one-cycle pulse when duty_cycle_o takes a new result.
REQ-009 SHALL have port timeout_o  output  1: one-cycle pulse, coincident with valid_o, when the result comes from timeout.

Function
REQ-010 SHALL synchronise pwm_i through two flops; "edge" means synchronised low->high, detected by comparison with a third flop.
REQ-011 SHALL implement states IDLE, MEASURE and DIVIDE.
REQ-012 SHALL, in IDLE, move on an edge to MEASURE with period_cnt=1 and high_cnt=1, producing no result.
REQ-013 SHALL, in MEASURE, increment 32-bit period_cnt every cycle, and increment 32-bit high_cnt on cycles where the synchronised input is high.
REQ-014 SHALL, on an edge in MEASURE, capture period_cap=period_cnt and high_cap=high_cnt, reload both counters to 1, and enter DIVIDE.
REQ-015 SHALL compute duty = floor(high_cap*100/period_cap) with a restoring divider: 7 quotient bits, one per cycle, MSB first, 7 cycles in DIVIDE.
REQ-016 SHALL pulse valid_o and update duty_cycle_o exactly 8 clocks after the edge-detect cycle, then return to MEASURE.
REQ-017 SHALL keep counting in period_cnt and high_cnt while in DIVIDE.
REQ-018 SHALL, on an edge while in DIVIDE (period < 8 clocks), reload the counters to 1 and not start a new division; the in-progress result is still delivered.
REQ-019 SHALL clamp duty_cycle_o to 100 if the quotient exceeds 100.
REQ-020 SHALL fire a timeout when c_timeout clocks elapse with no edge, counted from reset, the last edge, or the last timeout.
REQ-021 SHALL, on timeout, set duty_cycle_o to 100 if the synchronised input is high, else 0; pulse valid_o and timeout_o; and enter IDLE.
REQ-022 SHALL repeat the timeout every c_timeout clocks while no edge occurs.
REQ-023 SHALL saturate all counters at 32'hFFFF_FFFF and never wrap.
REQ-024 SHALL hold duty_cycle_o between results.

Reset
REQ-025 SHALL, while rst is high, immediately force duty_cycle_o=0, valid_o=0, timeout_o=0, all synchroniser flops 0, all counters 0 and state IDLE.
REQ-026 SHALL abort any division on reset and emit no result for it.
REQ-027 SHALL, after reset release, require two edges before the first non-timeout result.

Configuration
REQ-028 SHALL, with macro PWM_CAPTURE_PERIOD_OUT_EN defined, add port period_o  output  32, which loads period_cap in the same cycle as valid_o and is reset to 0; on timeout it SHALL load 0.
REQ-029 SHALL, without PWM_CAPTURE_PERIOD_OUT_EN, omit period_o and its register; all other behaviour is identical.

Verification
Bench parameters: clk_freq=1000, pwm_freq=10 (c_timerlim=100, c_timeout=200).
REQ-030 SHALL cover: repeating 30 high / 70 low -> duty_cycle_o=30, valid_o every 100 clocks, first result on the second edge plus 8 clocks, timeout_o never asserted.
REQ-031 SHALL cover: 33 high / 67 low -> 33 (truncation); 1 high / 99 low -> 1; 99 high / 1 low -> 99.
REQ-032 SHALL cover: input held low from reset release -> valid_o and timeout_o pulse at 200 and 400 clocks with duty_cycle_o=0 each time.
REQ-033 SHALL cover: edge, then input held high -> timeout pulse 200 clocks after the edge with duty_cycle_o=100.
REQ-034 SHALL cover: rst asserted 3 clocks into DIVIDE -> outputs 0 immediately, no valid_o, next result only after two fresh edges.
REQ-035 SHALL cover: a 5-clock glitch period inserted in a 30/70 stream -> no result for the glitch edge, and the correct result for the next full period.
